uart_tx_fifo_engine: RTL and testbench

UART_TX_FIFO_ENGINE -- requirements
Module: uart_tx_fifo_engine

---
 rtl/uart_tx_fifo_engine_if.sv | 39 +++
 rtl/uart_tx_fifo_engine.sv | 201 ++++++++++++++++++++
 tb/tb_uart_tx_fifo_engine.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_engine_if.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_engine_if
// Bundles the host-side signals of the UART transmit engine.
//   master : host side. Drives wr_en/wr_data/baud_div/par_odd/ie/clr_ovr and
//            observes tx and the FIFO/frame status.
//   slave  : engine side. The same signals with the opposite directions.
// Parameters must match those of the engine instance that uses the interface.
// -----------------------------------------------------------------------------
interface uart_tx_fifo_engine_if #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int DIV_W  = 16
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              wr_en;     // push wr_data this cycle
   logic [DATA_W-1:0] wr_data;   // character to transmit
   logic [DIV_W-1:0]  baud_div;  // bit period minus one, in clk cycles
   logic              par_odd;   // 1 = odd parity, 0 = even parity
   logic              ie;        // interrupt enable
   logic              clr_ovr;   // clear sticky overrun flag
   logic              tx;        // serial output, idle high
   logic              full;
   logic              empty;
   logic [CNT_W-1:0]  count;     // FIFO occupancy
   logic              busy;      // frame in progress
   logic              ovr;       // sticky overrun flag
   logic              nint;      // low = transmitter drained (when ie=1)

   modport master (
      output wr_en, wr_data, baud_div, par_odd, ie, clr_ovr,
      input  tx, full, empty, count, busy, ovr, nint
   );

   modport slave (
      input  wr_en, wr_data, baud_div, par_odd, ie, clr_ovr,
      output tx, full, empty, count, busy, ovr, nint
   );
endinterface

// File: rtl/uart_tx_fifo_engine.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_engine
// UART transmitter fed by a power-of-two TX FIFO.
//   clk  : single clock, rising edge
//   rst  : asynchronous active-high reset; aborts any frame, empties the FIFO
//   bus  : uart_tx_fifo_engine_if.slave (write port, config, tx, status)
// Frame: start(0), DATA_W data bits LSB first, optional parity, stop(1).
// Each bit lasts baud_div+1 cycles. baud_div and par_odd are captured when a
// frame starts and held for that frame. When the stop bit ends and the FIFO
// still holds data, the next start bit follows with no idle gap.
// Optional feature: define UART_PARITY_EN to insert a parity bit equal to
// XOR(data bits) ^ par_odd. Without it, par_odd is ignored.
// -----------------------------------------------------------------------------
module uart_tx_fifo_engine #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int DIV_W  = 16
) (
   input logic                  clk,
   input logic                  rst,
   uart_tx_fifo_engine_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = $clog2(DATA_W);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t            state_q,    state_d;
   logic              tx_q,       tx_d;
   logic [DIV_W-1:0]  baud_cnt_q, baud_cnt_d;
   logic [DIV_W-1:0]  div_q,      div_d;
   logic [DATA_W-1:0] shift_q,    shift_d;
   logic [BW-1:0]     bit_idx_q,  bit_idx_d;
   logic [AW-1:0]     wr_ptr_q,   wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q,   rd_ptr_d;
   logic [CW-1:0]     count_q,    count_d;
   logic              ovr_q,      ovr_d;
`ifdef UART_PARITY_EN
   logic              par_bit_q,  par_bit_d;
`else
   logic              unused_par_odd;
   assign unused_par_odd = bus.par_odd;
`endif

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic full, empty, bit_done, pop, push;

   assign full     = (count_q == CW'(DEPTH));
   assign empty    = (count_q == '0);
   assign bit_done = (baud_cnt_q == div_q);

   always_comb begin
      // NOTE: every _d starts at its _q value so no path leaves it unassigned,
      // which would infer a latch.
      state_d    = state_q;
      tx_d       = tx_q;
      baud_cnt_d = baud_cnt_q + DIV_W'(1);
      div_d      = div_q;
      shift_d    = shift_q;
      bit_idx_d  = bit_idx_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      ovr_d      = ovr_q;
`ifdef UART_PARITY_EN
      par_bit_d  = par_bit_q;
`endif
      pop        = 1'b0;

      case (state_q)
         IDLE: begin
            tx_d       = 1'b1;
            baud_cnt_d = '0;
            pop        = !empty;
         end
         START: begin
            if (bit_done) begin
               state_d    = DATA;
               tx_d       = shift_q[0];
               bit_idx_d  = '0;
               baud_cnt_d = '0;
            end
         end
         DATA: begin
            if (bit_done) begin
               baud_cnt_d = '0;
               if (bit_idx_q == BW'(DATA_W - 1)) begin
`ifdef UART_PARITY_EN
                  state_d = PARITY;
                  tx_d    = par_bit_q;
`else
                  state_d = STOP;
                  tx_d    = 1'b1;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + BW'(1);
                  shift_d   = shift_q >> 1;
                  tx_d      = shift_q[1];
               end
            end
         end
`ifdef UART_PARITY_EN
         PARITY: begin
            if (bit_done) begin
               state_d    = STOP;
               tx_d       = 1'b1;
               baud_cnt_d = '0;
            end
         end
`endif
         STOP: begin
            if (bit_done) begin
               baud_cnt_d = '0;
               if (empty) begin
                  state_d = IDLE;
                  tx_d    = 1'b1;
               end else begin
                  pop = 1'b1;
               end
            end
         end
         default: begin
            state_d    = IDLE;
            tx_d       = 1'b1;
            baud_cnt_d = '0;
         end
      endcase

      // Frame start: take the FIFO head and capture this frame's settings.
      if (pop) begin
         state_d    = START;
         tx_d       = 1'b0;
         baud_cnt_d = '0;
         shift_d    = mem_q[rd_ptr_q];
         div_d      = bus.baud_div;
         rd_ptr_d   = rd_ptr_q + AW'(1);
`ifdef UART_PARITY_EN
         par_bit_d  = (^mem_q[rd_ptr_q]) ^ bus.par_odd;
`endif
      end

      // A pop in the same cycle frees the slot, so a write to a full FIFO
      // is still accepted then.
      push = bus.wr_en && (!full || pop);
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);

      // Set wins over clear.
      if (bus.wr_en && full && !pop) ovr_d = 1'b1;
      else if (bus.clr_ovr)          ovr_d = 1'b0;
   end

   // NOTE: storage array is not reset; occupancy is tracked by the pointers
   // and count, so stale entries are never read.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= bus.wr_data;
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples values from before the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         tx_q       <= 1'b1;
         baud_cnt_q <= '0;
         div_q      <= '0;
         shift_q    <= '0;
         bit_idx_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ovr_q      <= 1'b0;
`ifdef UART_PARITY_EN
         par_bit_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         tx_q       <= tx_d;
         baud_cnt_q <= baud_cnt_d;
         div_q      <= div_d;
         shift_q    <= shift_d;
         bit_idx_q  <= bit_idx_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         ovr_q      <= ovr_d;
`ifdef UART_PARITY_EN
         par_bit_q  <= par_bit_d;
`endif
      end
   end

   assign bus.tx    = tx_q;
   assign bus.full  = full;
   assign bus.empty = empty;
   assign bus.count = count_q;
   assign bus.busy  = (state_q != IDLE);
   assign bus.ovr   = ovr_q;
   assign bus.nint  = !(bus.ie && empty && (state_q == IDLE));
endmodule

// File: tb/tb_uart_tx_fifo_engine.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo_engine
// Drives the UART TX engine with directed and random traffic and compares all
// outputs every cycle against a frame-level reference: a queue of pending
// characters plus a queue of per-cycle TX levels for the frame being sent.
// Build with +define+UART_PARITY_EN to exercise the parity variant.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo_engine;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 4;
   localparam int DIV_W  = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   uart_tx_fifo_engine_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DIV_W(DIV_W)) bus ();

   uart_tx_fifo_engine #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   // Reference model state
   logic [DATA_W-1:0] m_fifo[$];
   logic              m_line[$];   // TX level for each remaining cycle of the frame
   logic              m_ovr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_fifo.delete();
      m_line.delete();
      m_ovr = 1'b0;
   endtask

   // One rising edge of the reference, using the inputs present at that edge.
   task automatic model_edge();
      bit pop, full_now;
      logic [DATA_W-1:0] d;
      int reps;
      if (rst) begin
         model_reset();
         return;
      end
      pop      = (m_fifo.size() > 0) && (m_line.size() <= 1);
      full_now = (m_fifo.size() == DEPTH);
      if (m_line.size() > 0) void'(m_line.pop_front());
      if (bus.wr_en && full_now && !pop) m_ovr = 1'b1;
      else if (bus.clr_ovr)              m_ovr = 1'b0;
      if (pop) begin
         d    = m_fifo.pop_front();
         reps = int'(bus.baud_div) + 1;
         repeat (reps) m_line.push_back(1'b0);
         for (int i = 0; i < DATA_W; i++) repeat (reps) m_line.push_back(d[i]);
`ifdef UART_PARITY_EN
         repeat (reps) m_line.push_back((^d) ^ bus.par_odd);
`endif
         repeat (reps) m_line.push_back(1'b1);
      end
      if (bus.wr_en && (!full_now || pop)) m_fifo.push_back(bus.wr_data);
   endtask

   task automatic check_outputs();
      logic exp_tx, exp_busy;
      exp_tx   = (m_line.size() > 0) ? m_line[0] : 1'b1;
      exp_busy = (m_line.size() > 0);
      check("tx",    32'(bus.tx),    32'(exp_tx));
      check("busy",  32'(bus.busy),  32'(exp_busy));
      check("count", 32'(bus.count), 32'(m_fifo.size()));
      check("full",  32'(bus.full),  32'(m_fifo.size() == DEPTH));
      check("empty", 32'(bus.empty), 32'(m_fifo.size() == 0));
      check("ovr",   32'(bus.ovr),   32'(m_ovr));
      check("nint",  32'(bus.nint),  32'(!(bus.ie && m_fifo.size() == 0 && !exp_busy)));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      cyc++;
      check_outputs();
   endtask

   task automatic write(input logic [DATA_W-1:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_data = d;
      step();
      bus.wr_en   = 1'b0;
   endtask

   task automatic drain(input int budget);
      int k = 0;
      while ((m_line.size() > 0 || m_fifo.size() > 0) && k < budget) begin
         step();
         k++;
      end
      check("drain_within_budget", 32'(k < budget), 32'd1);
      step();
   endtask

   initial begin
      bus.wr_en    = 1'b0;
      bus.wr_data  = '0;
      bus.baud_div = 16'd3;
      bus.par_odd  = 1'b0;
      bus.ie       = 1'b1;
      bus.clr_ovr  = 1'b0;

      // Reset state, with ie=1 so nint must be low while reset holds.
      #2 rst = 1'b1;
      model_reset();
      #1 check_outputs();
      step();
      step();
      rst = 1'b0;
      step();

      // 0xA5 at baud_div=3: 40-cycle frame without parity.
      write(8'hA5);
      drain(200);

      // baud_div=0: one cycle per bit.
      bus.baud_div = 16'd0;
      write(8'h55);
      drain(50);

      // Back-to-back frames 0x00 then 0xFF.
      bus.baud_div = 16'd1;
      bus.wr_en    = 1'b1;
      bus.wr_data  = 8'h00;
      step();
      bus.wr_data  = 8'hFF;
      step();
      bus.wr_en    = 1'b0;
      drain(200);

      // Fill to full at baud_div=10, then overrun; dropped byte must not appear.
      bus.baud_div = 16'd10;
      bus.wr_en    = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bus.wr_data = 8'h11 + 8'(i);
         step();
      end
      // Simultaneous overrun and clear keeps the flag set.
      bus.wr_data = 8'hEE;
      bus.clr_ovr = 1'b1;
      step();
      bus.wr_en   = 1'b0;
      step();
      bus.clr_ovr = 1'b0;
      step();
      drain(2000);

      // Parity settings captured per frame (only affects TX with parity built in).
      bus.baud_div = 16'd2;
      bus.par_odd  = 1'b0;
      write(8'h07);
      drain(200);
      bus.par_odd  = 1'b1;
      write(8'h07);
      drain(200);

      // Random traffic with changing settings between and during frames.
      for (int i = 0; i < 600; i++) begin
         bus.wr_en    = ($urandom_range(0, 5) == 0);
         bus.wr_data  = DATA_W'($urandom);
         bus.baud_div = DIV_W'($urandom_range(0, 2));
         bus.par_odd  = 1'($urandom);
         bus.ie       = ($urandom_range(0, 3) != 0);
         bus.clr_ovr  = ($urandom_range(0, 19) == 0);
         step();
      end
      bus.wr_en   = 1'b0;
      bus.clr_ovr = 1'b1;
      bus.ie      = 1'b1;
      drain(3000);
      bus.clr_ovr = 1'b0;

      // Reset in the middle of data bit 3 with more bytes queued.
      bus.baud_div = 16'd3;
      bus.wr_en    = 1'b1;
      bus.wr_data  = 8'hC3;
      step();
      bus.wr_data  = 8'h3C;
      step();
      bus.wr_data  = 8'h5A;
      step();
      bus.wr_en    = 1'b0;
      repeat (16) step();
      #2 rst = 1'b1;
      model_reset();
      #1 check_outputs();
      step();
      rst = 1'b0;
      repeat (30) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
